// File: rtl/state_receiver.sv
// Deserializer for the inter-FPGA player-state link (sel/data_clk/data).
// Optional even-parity bit after the payload: define RX_PARITY_EN.
module state_receiver #(
  parameter int DATA_WIDTH     = 89,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_in,
  input  logic                  data_in,
  input  logic                  data_clk_in,
  input  logic                  sel_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  frame_error_out,
  output logic [1:0]            error_code_out
);

`ifdef RX_PARITY_EN
  localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
  localparam int FRAME_BITS = DATA_WIDTH;
`endif
  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] C_SAT  = CW'(FRAME_BITS + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_DRAIN
  } state_t;

  logic r_data_s1, r_data_s2;
  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_sel_s1, r_sel_s2, r_sel_d;

  state_t                r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [TW-1:0]         r_tmr, w_tmr_nxt;
  logic [DATA_WIDTH-1:0] r_data_out, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_err, w_err_nxt;
  logic [1:0]            r_code, w_code_nxt;

  logic                  w_clk_rise;
  logic                  w_sel_fall;
  logic                  w_sel_rise;
  logic [DATA_WIDTH-1:0] w_payload;

  // Synchronizers rest at the idle line levels so reset never fakes an edge
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      r_data_s1 <= 1'b0;
      r_data_s2 <= 1'b0;
      r_clk_s1  <= 1'b0;
      r_clk_s2  <= 1'b0;
      r_clk_d   <= 1'b0;
      r_sel_s1  <= 1'b1;
      r_sel_s2  <= 1'b1;
      r_sel_d   <= 1'b1;
    end else begin
      r_data_s1 <= data_in;
      r_data_s2 <= r_data_s1;
      r_clk_s1  <= data_clk_in;
      r_clk_s2  <= r_clk_s1;
      r_clk_d   <= r_clk_s2;
      r_sel_s1  <= sel_in;
      r_sel_s2  <= r_sel_s1;
      r_sel_d   <= r_sel_s2;
    end
  end

  assign w_clk_rise = r_clk_s2 & ~r_clk_d;
  assign w_sel_fall = ~r_sel_s2 & r_sel_d;
  assign w_sel_rise = r_sel_s2 & ~r_sel_d;
  assign w_payload  = r_shift[FRAME_BITS-1 -: DATA_WIDTH];

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_tmr      <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_code     <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmr      <= w_tmr_nxt;
      r_data_out <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      r_code     <= w_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_tmr_nxt   = r_tmr;
    w_data_nxt  = r_data_out;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = r_code;
    unique case (r_state)
      S_IDLE: begin
        if (w_sel_fall) begin
          w_state_nxt = S_RECV;
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_tmr_nxt   = '0;
        end
      end
      S_RECV: begin
        if (w_clk_rise) begin
          w_shift_nxt = {r_shift[FRAME_BITS-2:0], r_data_s2};
          w_cnt_nxt   = (r_cnt == C_SAT) ? r_cnt : r_cnt + 1'b1;
          w_tmr_nxt   = '0;
        end else if (r_tmr != T_MAX) begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
        // A bit arriving with the sel rise is already in the shift/count above
        if (w_sel_rise) begin
          w_state_nxt = S_CHECK;
        end else if (!w_clk_rise && r_tmr == T_MAX) begin
          w_state_nxt = S_DRAIN;
          w_err_nxt   = 1'b1;
          w_code_nxt  = 2'd2;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
        if (r_cnt != C_FULL) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = 2'd1;
        end
`ifdef RX_PARITY_EN
        else if (^r_shift) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = 2'd3;
        end
`endif
        else begin
          w_data_nxt  = w_payload;
          w_valid_nxt = 1'b1;
          w_code_nxt  = 2'd0;
        end
      end
      S_DRAIN: begin
        if (r_sel_s2) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign data_out        = r_data_out;
  assign data_out_valid  = r_valid;
  assign frame_error_out = r_err;
  assign error_code_out  = r_code;

endmodule

// File: tb/tb_state_receiver.sv
// Self-checking bench for state_receiver: directed and random frames
// against an outcome model of the link protocol.
module tb_state_receiver;
  localparam int DW = 89;
`ifdef RX_PARITY_EN
  localparam int FB = DW + 1;
`else
  localparam int FB = DW;
`endif

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          data = 1'b0;
  logic          dclk = 1'b0;
  logic          sel  = 1'b1;
  logic [DW-1:0] dout;
  logic          vld;
  logic          ferr;
  logic [1:0]    code;

  state_receiver #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(4096)) dut (
    .clk_pixel_in   (clk),
    .rst_in         (rst),
    .data_in        (data),
    .data_clk_in    (dclk),
    .sel_in         (sel),
    .data_out       (dout),
    .data_out_valid (vld),
    .frame_error_out(ferr),
    .error_code_out (code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_err = 0, lv = -1, le = -1;
  always @(negedge clk) begin
    if (vld) begin n_valid++; lv = cyc; end
    if (ferr) begin n_err++; le = cyc; end
  end

  int n_assert = 0, n_fail = 0;
  logic [DW-1:0] m_data = '0;
  logic [1:0]    m_code = 2'd0;
  bit            m_good;
  int            rise, last_rise, base_v, base_e;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic logic [127:0] rnd_bits();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Wire image of a frame: payload MSB first, then optional parity
  function automatic logic [127:0] mk(input logic [DW-1:0] pl, input bit flip);
    logic [127:0] r;
    r = '0;
`ifdef RX_PARITY_EN
    r[DW:0] = {pl, (^pl) ^ flip};
`else
    r[DW-1:0] = pl;
`endif
    return r;
  endfunction

  task automatic bits(input logic [127:0] fb, input int n, input int hp,
                      input bit merge);
    for (int i = n - 1; i >= 0; i--) begin
      data = fb[i];
      cyc_wait(hp);
      dclk = 1'b1;
      last_rise = cyc;
      if (merge && i == 0) begin
        sel = 1'b1;
        rise = cyc;
      end
      cyc_wait(hp);
      dclk = 1'b0;
    end
  endtask

  task automatic send(input logic [127:0] fb, input int n, input int hp,
                      input bit merge);
    base_v = n_valid;
    base_e = n_err;
    @(negedge clk);
    sel = 1'b0;
    cyc_wait(3);
    bits(fb, n, hp, merge);
    if (!(merge && n > 0)) begin
      cyc_wait(hp);
      sel = 1'b1;
      rise = cyc;
    end
  endtask

  // Expected outcome of one frame from its length and parity alone
  task automatic model(input logic [DW-1:0] pl, input int n, input bit par_ok);
    m_good = (n == FB) && par_ok;
    if (m_good) begin
      m_data = pl;
      m_code = 2'd0;
    end else begin
      m_code = (n != FB) ? 2'd1 : 2'd3;
    end
  endtask

  task automatic check(input string tag, input int gap);
    cyc_wait(gap);
    #1;
    if (m_good) begin
      chk({tag, " valid_cnt"}, 128'(n_valid - base_v), 128'(1));
      chk({tag, " err_cnt"}, 128'(n_err - base_e), 128'(0));
      chk({tag, " latency"}, 128'(lv - rise), 128'(4));
    end else begin
      chk({tag, " valid_cnt"}, 128'(n_valid - base_v), 128'(0));
      chk({tag, " err_cnt"}, 128'(n_err - base_e), 128'(1));
      chk({tag, " latency"}, 128'(le - rise), 128'(4));
    end
    chk({tag, " data"}, 128'(dout), 128'(m_data));
    chk({tag, " code"}, 128'(code), 128'(m_code));
  endtask

  task automatic frame(input string tag, input logic [DW-1:0] pl,
                       input int n, input int hp, input bit merge,
                       input bit flip, input int gap);
    logic [127:0] fb;
    fb = (n == FB) ? mk(pl, flip) : rnd_bits();
    send(fb, n, hp, merge);
    model(pl, n, !flip);
    check(tag, gap);
  endtask

  logic [DW-1:0] w0, w1;
  int t0, k, n, hp;

  initial begin
    w0 = {3'b101, 11'b00000100001, 65'h1_2345_6789_ABCD_EF01, 10'b0101010101};

    cyc_wait(5);
    chk("rst data", 128'(dout), 128'(0));
    chk("rst valid", 128'(vld), 128'(0));
    chk("rst err", 128'(ferr), 128'(0));
    chk("rst code", 128'(code), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle outputs", 128'({dout, vld, ferr, code}), 128'(0));
    end

    frame("good_w0", w0, FB, 5, 1'b0, 1'b0, 8);
    frame("short", '0, FB - 1, 4, 1'b0, 1'b0, 8);
    frame("long", '0, FB + 1, 4, 1'b0, 1'b0, 8);
    frame("zero_bits", '0, 0, 3, 1'b0, 1'b0, 8);

    // Mid-frame stall: timeout, then toggles ignored until sel returns high
    base_v = n_valid;
    base_e = n_err;
    @(negedge clk);
    sel = 1'b0;
    cyc_wait(3);
    bits(rnd_bits(), 10, 4, 1'b0);
    t0 = last_rise;
    m_code = 2'd2;
    cyc_wait(4200);
    #1;
    chk("timeout err_cnt", 128'(n_err - base_e), 128'(1));
    chk("timeout code", 128'(code), 128'(m_code));
    chk("timeout lat_ok", 128'((le - t0 >= 4096) && (le - t0 <= 4104)), 128'(1));
    bits(rnd_bits(), 5, 4, 1'b0);
    sel = 1'b1;
    cyc_wait(10);
    #1;
    chk("drain err_cnt", 128'(n_err - base_e), 128'(1));
    chk("drain valid_cnt", 128'(n_valid - base_v), 128'(0));
    chk("drain data", 128'(dout), 128'(m_data));
    frame("after_timeout", rnd_word(), FB, 3, 1'b0, 1'b0, 8);

`ifdef RX_PARITY_EN
    w1 = rnd_word();
    frame("parity_ok", w1, FB, 4, 1'b0, 1'b0, 8);
    frame("parity_bad", rnd_word(), FB, 4, 1'b0, 1'b1, 8);
`endif

    frame("b2b_a", rnd_word(), FB, 3, 1'b0, 1'b0, 5);
    frame("b2b_b", rnd_word(), FB, 3, 1'b0, 1'b0, 8);
    frame("merged_edge", rnd_word(), FB, 3, 1'b1, 1'b0, 8);

    for (int i = 0; i < 10; i++) begin
`ifdef RX_PARITY_EN
      k = $urandom_range(0, 4);
`else
      k = $urandom_range(0, 3);
`endif
      hp = $urandom_range(3, 6);
      n = (k == 2) ? $urandom_range(1, FB - 1) :
          (k == 3) ? $urandom_range(FB + 1, FB + 30) : FB;
      frame("random", rnd_word(), n, hp, k == 1, k == 4, 8);
    end

    // Reset in the middle of a frame clears outputs at once and emits nothing
    base_v = n_valid;
    base_e = n_err;
    @(negedge clk);
    sel = 1'b0;
    cyc_wait(3);
    bits(rnd_bits(), 40, 3, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst data", 128'(dout), 128'(0));
    chk("async_rst flags", 128'({vld, ferr, code}), 128'(0));
    m_data = '0;
    m_code = 2'd0;
    sel = 1'b1;
    cyc_wait(3);
    rst = 1'b0;
    cyc_wait(10);
    #1;
    chk("post_rst valid_cnt", 128'(n_valid - base_v), 128'(0));
    chk("post_rst err_cnt", 128'(n_err - base_e), 128'(0));
    chk("post_rst data", 128'(dout), 128'(0));
    frame("recover", rnd_word(), FB, 4, 1'b0, 1'b0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
